fifo_serializer_tx: RTL and testbench
=====================================

// Module: fifo_serializer_tx
// PURPOSE
//  Drains the fifo from its read side and transmits each popped item on a narrow link.
//  Link handshake is 4-phase req/ack; each item is sent as SIZE/FLIT_W beats.
//  Sits between a router output fifo and an inter-router channel.
//  The fifo's item_out is combinational at its read pointer. Its read pops on the next clk edge.
// PARAMETERS
//  ID      -1  instance id, printed in $display trace lines
//  SIZE     8  item width in bits; must equal the fifo SIZE
//  FLIT_W   2  link data width; SIZE % FLIT_W must be 0
//  (local) BEATS = SIZE/FLIT_W; CNT_W = max(1, $clog2(BEATS))
// PORTS
//  clk         in   1       clock; all state updates on posedge
//  reset       in   1       synchronous, active-low reset (0 = reset)
//  fifo_empty  in   1       fifo empty flag
//  fifo_item   in   SIZE    fifo item_out (head of fifo)
//  fifo_read   out  1       pop request to fifo, single-cycle pulse
//  tx_req      out  1       link request; registered
//  tx_ack      in   1       link acknowledge from receiver
//  tx_data     out  FLIT_W  current beat; stable while tx_req=1
//  tx_last     out  1       high with tx_data on the final beat of an item
//  busy        out  1       high whenever state != IDLE
// BEHAVIOUR
//  Reset, sampled at posedge with reset=0:
//   - state=IDLE; shreg=0; beat_cnt=0
//   - fifo_read=0, tx_req=0, tx_data=0, tx_last=0, busy=0
//   - reset wins over all other inputs
//  States: IDLE, REQ, WAIT_LOW.
//  IDLE:
//   - fifo_read = (state==IDLE) & !fifo_empty & !tx_ack & reset. This is combinational.
//   - On an edge with fifo_read=1: shreg<=fifo_item, beat_cnt<=0, go to REQ.
//   - Exactly one pop per item. Never pop while fifo_empty=1.
//  REQ:
//   - tx_req=1; tx_data=shreg[FLIT_W-1:0], so items go out LSB-first.
//   - tx_last=(beat_cnt==BEATS-1).
//   - On an edge with tx_ack=1: go to WAIT_LOW; tx_req drops in the next cycle.
//  WAIT_LOW:
//   - tx_req=0; tx_data and tx_last hold their values.
//   - On an edge with tx_ack=0 and tx_last=1: go to IDLE.
//   - On an edge with tx_ack=0 and tx_last=0: shreg >>= FLIT_W, beat_cnt += 1, go to REQ.
//  Latency:
//   - fifo_read pulses in cycle k; tx_req rises in cycle k+1.
//   - Minimum beat period is 2 cycles with a zero-delay responder.
//   - Min item spacing is 2*BEATS+1 cycles (IDLE fetch cycle included).
//  Width: beat_cnt is CNT_W bits and never wraps; it reaches at most BEATS-1.
//   - BEATS=1 is legal: tx_last is constant 1 in REQ.
//  Boundaries:
//   - tx_ack high in IDLE is a protocol error. The block does not fetch until ack drops
//     and prints a $display warning with ID.
//   - fifo_empty is ignored outside IDLE, so a fifo refill mid-item has no effect.
//   - tx_ack is only sampled at edges; a 1-cycle ack pulse in REQ counts as an ack.
//   - Reset mid-item: the item already popped is lost, and no second pop occurs for it.
//     tx_req is low from the cycle after the reset edge.
//  Trace: one $display per pop, formatted "#%3d, %10s [%1d] : popped <%g> for tx".
// TESTING
//  1 reset=0 for 2 cycles with fifo_empty=0 -> every output 0; fifo_read stays 0 throughout.
//  2 SIZE=8, FLIT_W=2, item 8'hB4, zero-delay ack responder
//    -> tx_data beats 0,1,3,2
//    -> tx_last only on beat 4; one fifo_read pulse; tx_req rises 1 cycle after the pop.
//  3 Back-to-back items 8'h1E then 8'hE1 -> beats 2,3,1,0 then 1,0,2,3
//    -> second fifo_read pulses only after beat 4 ack falls; no overlap between items.
//  4 Responder delays ack 5 cycles per beat -> tx_req/tx_data/tx_last stay stable until ack
//    -> no beat dropped or duplicated.
//  5 reset=0 for 1 cycle while in REQ on beat 2 -> next cycle tx_req=0, busy=0
//    -> the next item starts at beat 0 with a fresh pop.
//  6 tx_ack held 1 in IDLE with fifo_empty=0 -> no fifo_read; warning printed
//    -> fetch occurs on the first edge after tx_ack=0.

Source files
------------

// File: rtl/fifo_serializer_tx.sv
// Pops items from the head of a fifo and sends each one LSB-first as SIZE/FLIT_W beats
// over a 4-phase req/ack link.
module fifo_serializer_tx #(
  parameter int ID     = -1,
  parameter int SIZE   = 8,
  parameter int FLIT_W = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fifo_empty,
  input  logic [SIZE-1:0]   fifo_item,
  output logic              fifo_read,
  output logic              tx_req,
  input  logic              tx_ack,
  output logic [FLIT_W-1:0] tx_data,
  output logic              tx_last,
  output logic              busy
);

  localparam int BEATS = SIZE / FLIT_W;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ      = 2'd1,
    WAIT_LOW = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [SIZE-1:0]   shreg_q, shreg_d;
  logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;
  logic              tx_req_q, tx_req_d;
  logic [FLIT_W-1:0] tx_data_q, tx_data_d;
  logic              tx_last_q, tx_last_d;

  // An ack still high in IDLE means the previous handshake never closed, so hold the fetch.
  assign fifo_read = (state_q == IDLE) & ~fifo_empty & ~tx_ack & reset;

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    beat_cnt_d = beat_cnt_q;
    tx_req_d   = tx_req_q;
    tx_data_d  = tx_data_q;
    tx_last_d  = tx_last_q;
    case (state_q)
      IDLE: begin
        if (fifo_read) begin
          shreg_d    = fifo_item;
          beat_cnt_d = '0;
          tx_req_d   = 1'b1;
          tx_data_d  = fifo_item[FLIT_W-1:0];
          tx_last_d  = (LAST_CNT == '0);
          state_d    = REQ;
        end
      end
      REQ: begin
        if (tx_ack) begin
          tx_req_d = 1'b0;
          state_d  = WAIT_LOW;
        end
      end
      WAIT_LOW: begin
        if (!tx_ack) begin
          if (tx_last_q) begin
            state_d = IDLE;
          end else begin
            shreg_d    = shreg_q >> FLIT_W;
            beat_cnt_d = beat_cnt_q + CNT_W'(1);
            tx_req_d   = 1'b1;
            tx_data_d  = shreg_d[FLIT_W-1:0];
            tx_last_d  = (beat_cnt_d == LAST_CNT);
            state_d    = REQ;
          end
        end
      end
      default: begin
        tx_req_d = 1'b0;
        state_d  = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      shreg_q    <= '0;
      beat_cnt_q <= '0;
      tx_req_q   <= 1'b0;
      tx_data_q  <= '0;
      tx_last_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      beat_cnt_q <= beat_cnt_d;
      tx_req_q   <= tx_req_d;
      tx_data_q  <= tx_data_d;
      tx_last_q  <= tx_last_d;
    end
  end

  assign tx_req  = tx_req_q;
  assign tx_data = tx_data_q;
  assign tx_last = tx_last_q;
  assign busy    = (state_q != IDLE);

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (fifo_read)
      $display("#%3d, %10s [%1d] : popped <%g> for tx", $time, "fifo_ser", ID, $itor(fifo_item));
    if (reset && state_q == IDLE && tx_ack)
      $display("#%3d, %10s [%1d] : warning, tx_ack high in IDLE, fetch held", $time, "fifo_ser", ID);
  end
`endif

endmodule

// File: tb/tb_fifo_serializer_tx.sv
// Directed bench for fifo_serializer_tx (SIZE=8, FLIT_W=2): vector table plus corner sequences.
module tb_fifo_serializer_tx;

  logic       clk;
  logic       reset;
  logic       fifo_empty;
  logic [7:0] fifo_item;
  logic       fifo_read;
  logic       tx_req;
  logic       tx_ack;
  logic [1:0] tx_data;
  logic       tx_last;
  logic       busy;

  fifo_serializer_tx #(.ID(3), .SIZE(8), .FLIT_W(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .fifo_empty (fifo_empty),
    .fifo_item  (fifo_item),
    .fifo_read  (fifo_read),
    .tx_req     (tx_req),
    .tx_ack     (tx_ack),
    .tx_data    (tx_data),
    .tx_last    (tx_last),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Fifo model: item_out combinational at the read pointer, pop on the edge.
  logic [7:0] mem [16];
  logic [3:0] rd_p = '0;
  logic [3:0] wr_p = '0;
  assign fifo_empty = (rd_p == wr_p);
  assign fifo_item  = mem[rd_p];
  always @(posedge clk) if (fifo_read) rd_p <= rd_p + 4'd1;

  // Responder: 0 = zero-delay (ack follows req), 1 = ack after ACK_DLY cycles, 2 = manual.
  localparam int ACK_DLY = 5;
  int   ack_mode = 2;
  logic ack_man  = 1'b0;
  logic ack_auto = 1'b0;
  int   dly_cnt  = 0;
  assign tx_ack = (ack_mode == 0) ? tx_req : (ack_mode == 1) ? ack_auto : ack_man;
  always @(posedge clk) begin
    if (ack_mode == 1) begin
      if (tx_req && !ack_auto) begin
        if (dly_cnt == ACK_DLY - 1) begin
          ack_auto <= 1'b1;
          dly_cnt  <= 0;
        end else begin
          dly_cnt <= dly_cnt + 1;
        end
      end else if (!tx_req) begin
        ack_auto <= 1'b0;
      end
    end else begin
      ack_auto <= 1'b0;
      dly_cnt  <= 0;
    end
  end

  // Link monitor, sampled mid-cycle.
  int         cyc = 0;
  logic       req_prev = 1'b0;
  logic [1:0] hold_data = '0;
  logic       hold_last = 1'b0;
  int         unstable = 0;
  int         bad_pop = 0;
  logic [1:0] beat_data [$];
  logic       beat_last [$];
  int         pop_cyc [$];
  int         rise_cyc [$];
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (fifo_read) pop_cyc.push_back(cyc);
    if (fifo_read && fifo_empty) bad_pop <= bad_pop + 1;
    if (tx_req && !req_prev) begin
      beat_data.push_back(tx_data);
      beat_last.push_back(tx_last);
      rise_cyc.push_back(cyc);
      hold_data <= tx_data;
      hold_last <= tx_last;
    end else if (tx_req && (tx_data != hold_data || tx_last != hold_last)) begin
      unstable <= unstable + 1;
    end
    req_prev <= tx_req;
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] item);
    mem[wr_p] = item;
    wr_p = wr_p + 4'd1;
  endtask

  task automatic clear_mon();
    beat_data.delete();
    beat_last.delete();
    pop_cyc.delete();
    rise_cyc.delete();
  endtask

  task automatic wait_beats(input int n, input int budget);
    int k = 0;
    while (beat_data.size() < n && k < budget) begin
      tick();
      k++;
    end
    chk("beat_timeout", 32'(beat_data.size() >= n), 1);
  endtask

  typedef struct {
    logic [7:0] item;
    int         mode;
    logic [1:0] b0, b1, b2, b3;
  } vec_t;

  vec_t vecs [7];

  initial begin
    logic [1:0] exp_b [4];
    int k;

    vecs[0] = '{8'hB4, 0, 2'd0, 2'd1, 2'd3, 2'd2};
    vecs[1] = '{8'h1E, 0, 2'd2, 2'd3, 2'd1, 2'd0};
    vecs[2] = '{8'hE1, 0, 2'd1, 2'd0, 2'd2, 2'd3};
    vecs[3] = '{8'h27, 1, 2'd3, 2'd1, 2'd2, 2'd0};
    vecs[4] = '{8'h6C, 1, 2'd0, 2'd3, 2'd2, 2'd1};
    vecs[5] = '{8'hFF, 0, 2'd3, 2'd3, 2'd3, 2'd3};
    vecs[6] = '{8'h00, 0, 2'd0, 2'd0, 2'd0, 2'd0};

    // Reset held two cycles with the fifo non-empty (it already holds vecs[0]).
    reset = 1'b0;
    push(8'hB4);
    tick();
    chk("rst_outs_c1", {fifo_read, tx_req, tx_data, tx_last, busy}, 0);
    tick();
    chk("rst_outs_c2", {fifo_read, tx_req, tx_data, tx_last, busy}, 0);
    chk("rst_no_pop", pop_cyc.size(), 0);

    // Vector table: vecs[0] is launched by releasing reset, the rest by a push.
    for (int i = 0; i < 7; i++) begin
      clear_mon();
      ack_mode = vecs[i].mode;
      if (i == 0) reset = 1'b1;
      else push(vecs[i].item);
      exp_b[0] = vecs[i].b0;
      exp_b[1] = vecs[i].b1;
      exp_b[2] = vecs[i].b2;
      exp_b[3] = vecs[i].b3;
      wait_beats(4, 120);
      repeat (10) tick();
      chk($sformatf("v%0d_nbeats", i), beat_data.size(), 4);
      chk($sformatf("v%0d_npops", i), pop_cyc.size(), 1);
      chk($sformatf("v%0d_req_lat", i), rise_cyc[0] - pop_cyc[0], 1);
      for (int j = 0; j < 4; j++) begin
        chk($sformatf("v%0d_b%0d_data", i, j), beat_data[j], exp_b[j]);
        chk($sformatf("v%0d_b%0d_last", i, j), beat_last[j], (j == 3) ? 1 : 0);
      end
      if (vecs[i].mode == 0)
        chk($sformatf("v%0d_beat_period", i), rise_cyc[3] - rise_cyc[0], 6);
      chk($sformatf("v%0d_idle", i), {busy, tx_req}, 0);
    end
    chk("stable_while_req", unstable, 0);

    // Back-to-back items: second pop only after the first item's last handshake closes.
    clear_mon();
    ack_mode = 0;
    push(8'h1E);
    push(8'hE1);
    wait_beats(8, 200);
    repeat (4) tick();
    chk("b2b_npops", pop_cyc.size(), 2);
    chk("b2b_spacing", pop_cyc[1] - pop_cyc[0], 9);
    chk("b2b_after_last", 32'(pop_cyc[1] > rise_cyc[3] + 1), 1);
    chk("b2b_beats", {beat_data[0], beat_data[1], beat_data[2], beat_data[3],
                      beat_data[4], beat_data[5], beat_data[6], beat_data[7]}, 16'b10_11_01_00_01_00_10_11);
    chk("b2b_lasts", {beat_last[0], beat_last[1], beat_last[2], beat_last[3],
                      beat_last[4], beat_last[5], beat_last[6], beat_last[7]}, 8'b0001_0001);

    // Reset while in REQ on the second beat: that item is dropped, next item gets a fresh pop.
    clear_mon();
    ack_mode = 2;
    ack_man  = 1'b0;
    push(8'h4B);
    push(8'hD2);
    k = 0;
    while (!tx_req && k < 20) begin
      tick();
      k++;
    end
    chk("rstmid_req_up", tx_req, 1);
    ack_man = 1'b1;
    tick();
    ack_man = 1'b0;
    tick();
    chk("rstmid_beat2", {tx_req, tx_data}, {1'b1, 2'd2});
    reset = 1'b0;
    tick();
    chk("rstmid_after", {tx_req, busy, tx_data, tx_last}, 0);
    reset    = 1'b1;
    ack_mode = 0;
    #1;
    chk("rstmid_fresh_read", fifo_read, 1);
    wait_beats(6, 100);
    repeat (4) tick();
    chk("rstmid_npops", pop_cyc.size(), 2);
    chk("rstmid_nbeats", beat_data.size(), 6);
    chk("rstmid_beats", {beat_data[0], beat_data[1], beat_data[2], beat_data[3],
                         beat_data[4], beat_data[5]}, 12'b11_10_10_00_01_11);
    chk("rstmid_lasts", {beat_last[0], beat_last[1], beat_last[2], beat_last[3],
                         beat_last[4], beat_last[5]}, 6'b000001);

    // Ack stuck high in IDLE with a non-empty fifo: no fetch until it drops.
    clear_mon();
    ack_mode = 2;
    ack_man  = 1'b1;
    push(8'h93);
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("ackidle_noread_c%0d", c), {fifo_read, busy}, 0);
      tick();
    end
    chk("ackidle_npops", pop_cyc.size(), 0);
    ack_man  = 1'b0;
    ack_mode = 0;
    #1;
    chk("ackidle_read", fifo_read, 1);
    tick();
    chk("ackidle_fetched", {busy, tx_req, tx_data}, {1'b1, 1'b1, 2'd3});
    wait_beats(4, 60);
    repeat (4) tick();
    chk("ackidle_beats", {beat_data[0], beat_data[1], beat_data[2], beat_data[3]}, 8'b11_00_01_10);
    chk("ackidle_npops2", pop_cyc.size(), 1);

    chk("no_pop_when_empty", bad_pop, 0);
    chk("stable_final", unstable, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_chk);
    $fatal(1);
  end

endmodule
